// File: rtl/pipe_run_controller_if.sv
// Host/core-side bundle of the run controller: program stream, processor load port,
// observed registers and run status; master = host/bench side, slave = controller side.
interface pipe_run_controller_if #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int CNT_W       = 32
);
    localparam int LEN_W = $clog2(DEPTH_WORDS) + 1;

    logic             start;
    logic             mode;
    logic [WIDTH-1:0] expected;
    logic [LEN_W-1:0] prog_len;
    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_data;
    logic             cpu_reset;
    logic             memEn;
    logic [WIDTH-1:0] memAddr;
    logic [WIDTH-1:0] memData;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] a7;
    logic [WIDTH-1:0] a0;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [WIDTH-1:0] fail_code;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, mode, expected, prog_len, ld_valid, ld_data, gp, a7, a0,
        input  ld_ready, cpu_reset, memEn, memAddr, memData,
               busy, done, pass, timeout, fail_code, cycle_count
    );

    modport slave (
        input  start, mode, expected, prog_len, ld_valid, ld_data, gp, a7, a0,
        output ld_ready, cpu_reset, memEn, memAddr, memData,
               busy, done, pass, timeout, fail_code, cycle_count
    );
endinterface

// File: rtl/pipe_run_controller.sv
// Loads a program into the core, holds it in reset, runs it and reports pass/fail/timeout.
// Load writes appear one cycle after each ld_valid&&ld_ready; ld_ready is high only in LOAD.
module pipe_run_controller #(
    parameter int WIDTH          = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    pipe_run_controller_if.slave  bus
);
    localparam int LEN_W = $clog2(DEPTH_WORDS) + 1;
    localparam int HC_W  = $clog2(RESET_CYCLES) + 1;

    localparam logic [LEN_W-1:0] DEPTH_L    = LEN_W'(DEPTH_WORDS);
    localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_L  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] ECALL_EXIT = WIDTH'(93);
    localparam logic [WIDTH-1:0] GP_PASS    = WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    state_t           state, state_next;
    logic             mode_q;
    logic [WIDTH-1:0] expected_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [HC_W-1:0]  hold_cnt;

    logic             mem_en;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             done_q;
    logic             pass_q;
    logic             timeout_q;
    logic [WIDTH-1:0] fail_code_q;
    logic [CNT_W-1:0] cyc_cnt;

    logic             start_ok;
    logic [LEN_W-1:0] eff_len;
    logic             ld_fire;
    logic             hold_last;
    logic             hit;
    logic             hit_pass;
    logic             expired;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        eff_len    = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
        ld_fire    = 1'b0;
        hold_last  = 1'b0;
        hit        = 1'b0;
        hit_pass   = 1'b0;
        expired    = 1'b0;
        // The counter value written at this edge includes the current RUN edge.
        cnt_inc    = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + CNT_W'(1);
        case (state)
            S_IDLE, S_DONE: begin
                start_ok = bus.start;
                if (bus.start) state_next = (eff_len == '0) ? S_HOLD : S_LOAD;
            end
            S_LOAD: begin
                ld_fire = bus.ld_valid;
                if (ld_fire && idx == len_q - LEN_W'(1)) state_next = S_HOLD;
            end
            S_HOLD: begin
                hold_last = (hold_cnt == HOLD_LAST);
                if (hold_last) state_next = S_RUN;
            end
            S_RUN: begin
                if (mode_q) begin
                    hit      = (bus.a7 == ECALL_EXIT);
                    hit_pass = (bus.gp == GP_PASS);
                end else begin
                    hit      = (bus.a0 == expected_q);
                    hit_pass = 1'b1;
                end
                expired = (cnt_inc == TIMEOUT_L);
                if (hit || expired) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q      <= 1'b0;
            expected_q  <= '0;
            len_q       <= '0;
            idx         <= '0;
            hold_cnt    <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
            cyc_cnt     <= '0;
        end else begin
            mem_en <= ld_fire;
            if (ld_fire) begin
                mem_addr <= WIDTH'(idx) << 2;
                mem_data <= bus.ld_data;
                idx      <= idx + LEN_W'(1);
            end
            if (start_ok) begin
                mode_q      <= bus.mode;
                expected_q  <= bus.expected;
                len_q       <= eff_len;
                idx         <= '0;
                hold_cnt    <= '0;
                done_q      <= 1'b0;
                pass_q      <= 1'b0;
                timeout_q   <= 1'b0;
                fail_code_q <= '0;
                cyc_cnt     <= '0;
            end
            if (state == S_HOLD && !hold_last) hold_cnt <= hold_cnt + HC_W'(1);
            if (state == S_RUN) begin
                cyc_cnt <= cnt_inc;
                // A match on the timeout edge still counts as a match.
                if (hit) begin
                    done_q      <= 1'b1;
                    pass_q      <= hit_pass;
                    fail_code_q <= (mode_q && !hit_pass) ? (bus.gp >> 1) : '0;
                end else if (expired) begin
                    done_q    <= 1'b1;
                    timeout_q <= 1'b1;
                    pass_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.ld_ready    = (state == S_LOAD);
    assign bus.cpu_reset   = (state != S_RUN);
    assign bus.busy        = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN);
    assign bus.memEn       = mem_en;
    assign bus.memAddr     = mem_addr;
    assign bus.memData     = mem_data;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.timeout     = timeout_q;
    assign bus.fail_code   = fail_code_q;
    assign bus.cycle_count = cyc_cnt;
endmodule

// File: tb/tb_pipe_run_controller.sv
// Randomised scoreboard bench for pipe_run_controller: expected writes and run results
// are queued by the stimulus side and popped by an independent negedge monitor.
module tb_pipe_run_controller;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int RC    = 2;
    localparam int TO    = 50;
    localparam int CW    = 32;
    localparam int LEN_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [31:0] fail_code;
        logic [31:0] cycles;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipe_run_controller_if #(.WIDTH(WIDTH), .DEPTH_WORDS(DEPTH), .CNT_W(CW)) bus ();

    pipe_run_controller #(
        .WIDTH(WIDTH), .DEPTH_WORDS(DEPTH), .RESET_CYCLES(RC),
        .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    wr_t  q_mem[$];
    res_t q_res[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic        cfg_mode = 1'b0;
    logic [31:0] cfg_exp  = '0;
    logic [31:0] cfg_gp   = '0;
    int          cfg_m    = 0;
    int          run_n    = 0;

    int   mon_cyc = 0;
    int   anchor  = -1;
    logic done_q  = 1'b0;
    logic crst_q  = 1'b1;
    wr_t  mw;
    res_t mr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_cpu_reset",   64'(bus.cpu_reset),   64'd1);
        chk("rst_ld_ready",    64'(bus.ld_ready),    64'd0);
        chk("rst_memEn",       64'(bus.memEn),       64'd0);
        chk("rst_memAddr",     64'(bus.memAddr),     64'd0);
        chk("rst_memData",     64'(bus.memData),     64'd0);
        chk("rst_busy",        64'(bus.busy),        64'd0);
        chk("rst_done",        64'(bus.done),        64'd0);
        chk("rst_pass",        64'(bus.pass),        64'd0);
        chk("rst_timeout",     64'(bus.timeout),     64'd0);
        chk("rst_fail_code",   64'(bus.fail_code),   64'd0);
        chk("rst_cycle_count", 64'(bus.cycle_count), 64'd0);
    endtask

    // Register driver: presents the completion condition from RUN cycle cfg_m onwards.
    initial begin
        bus.a0 = '0;
        bus.a7 = '0;
        bus.gp = '0;
        forever begin
            @(negedge clock);
            if (!bus.cpu_reset) run_n++;
            else                run_n = 0;
            if (cfg_m != 0 && run_n >= cfg_m) begin
                if (cfg_mode) begin
                    bus.a7 = 32'd93;
                    bus.gp = cfg_gp;
                    bus.a0 = $urandom;
                end else begin
                    bus.a0 = cfg_exp;
                    bus.a7 = $urandom;
                    bus.gp = $urandom;
                end
            end else if (cfg_mode) begin
                bus.a7 = 32'($urandom_range(0, 92));
                bus.gp = $urandom;
                bus.a0 = $urandom;
            end else begin
                bus.a0 = cfg_exp + 32'd1 + 32'($urandom_range(0, 99));
                bus.a7 = $urandom;
                bus.gp = $urandom;
            end
        end
    end

    // Monitor: consumes expected writes and results as the DUT presents them.
    initial begin
        forever begin
            @(negedge clock);
            mon_cyc++;
            if (reset) begin
                anchor = -1;
                done_q = 1'b0;
                crst_q = 1'b1;
            end else begin
                if (bus.memEn) begin
                    anchor = mon_cyc;
                    if (q_mem.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_memEn: got write addr 0x%0h data 0x%0h, expected none",
                                 bus.memAddr, bus.memData);
                    end else begin
                        mw = q_mem.pop_front();
                        chk("memAddr", 64'(bus.memAddr), 64'(mw.addr));
                        chk("memData", 64'(bus.memData), 64'(mw.data));
                    end
                end
                if (crst_q && !bus.cpu_reset) begin
                    if (anchor >= 0) chk("hold_cycles", 64'(mon_cyc - anchor), 64'(RC));
                    anchor = -1;
                end
                if (bus.done && !done_q) begin
                    if (q_res.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got done=1, expected no completion");
                    end else begin
                        mr = q_res.pop_front();
                        chk("pass",        64'(bus.pass),        64'(mr.pass));
                        chk("timeout",     64'(bus.timeout),     64'(mr.timeout));
                        chk("fail_code",   64'(bus.fail_code),   64'(mr.fail_code));
                        chk("cycle_count", 64'(bus.cycle_count), 64'(mr.cycles));
                        chk("done_cpu_reset", 64'(bus.cpu_reset), 64'd1);
                        chk("done_busy",      64'(bus.busy),      64'd0);
                    end
                end
                done_q = bus.done;
                crst_q = bus.cpu_reset;
            end
        end
    end

    // gap: 0 = ld_valid always high, 1 = every other cycle, 2 = random.
    task automatic run_test(input logic m, input logic [31:0] exp, input int plen, input int gap,
                            input int mcyc, input logic [31:0] gpv, input bit fixed_data,
                            input bit start_in_run, input int abort_after);
        int   eff;
        int   idx;
        int   budget;
        bit   v;
        bit   tog;
        wr_t  w;
        res_t r;
        logic [31:0] d;

        eff = (plen > DEPTH) ? DEPTH : plen;
        if (mcyc >= 1 && mcyc <= TO) begin
            r.pass      = m ? (gpv == 32'd1) : 1'b1;
            r.timeout   = 1'b0;
            r.fail_code = (m && gpv != 32'd1) ? (gpv >> 1) : 32'd0;
            r.cycles    = 32'(mcyc);
        end else begin
            r.pass      = 1'b0;
            r.timeout   = 1'b1;
            r.fail_code = 32'd0;
            r.cycles    = 32'(TO);
        end

        @(negedge clock);
        cfg_mode = m;
        cfg_exp  = exp;
        cfg_gp   = gpv;
        cfg_m    = mcyc;
        bus.start    = 1'b1;
        bus.mode     = m;
        bus.expected = exp;
        bus.prog_len = LEN_W'(plen);
        q_res.push_back(r);

        @(negedge clock);
        bus.start    = 1'b0;
        bus.mode     = ~m;
        bus.expected = $urandom;
        bus.prog_len = LEN_W'($urandom);
        chk("busy_after_start",     64'(bus.busy),     64'd1);
        chk("ld_ready_after_start", 64'(bus.ld_ready), 64'(eff != 0));

        idx    = 0;
        budget = 0;
        tog    = 1'b1;
        while (idx < eff && budget < 200) begin
            v   = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            d   = fixed_data ? (32'h13 + 32'(idx) * 32'h80) : $urandom;
            bus.ld_valid = v;
            bus.ld_data  = d;
            if (v && bus.ld_ready) begin
                w.addr = 32'(idx * 4);
                w.data = d;
                q_mem.push_back(w);
                idx++;
            end
            budget++;
            @(negedge clock);
            if (abort_after != 0 && idx == abort_after) break;
        end

        if (abort_after != 0 && idx == abort_after) begin
            bus.ld_valid = 1'b0;
            #2 reset = 1'b1;
            @(negedge clock);
            check_reset_vals();
            void'(q_res.pop_back());
            #2 reset = 1'b0;
            return;
        end
        if (budget >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL load_stall: got %0d words accepted, expected %0d", idx, eff);
        end

        // Offer extra words: none may be taken once the length is reached.
        bus.ld_valid = 1'b1;
        bus.ld_data  = $urandom;
        repeat (3) @(negedge clock);
        bus.ld_valid = 1'b0;

        if (start_in_run) begin
            budget = 0;
            while (bus.cpu_reset && budget < 50) begin
                @(negedge clock);
                budget++;
            end
            repeat (2) @(negedge clock);
            bus.start    = 1'b1;
            bus.mode     = ~m;
            bus.prog_len = LEN_W'(3);
            @(negedge clock);
            bus.start = 1'b0;
            chk("run_start_ignored_ld_ready", 64'(bus.ld_ready),  64'd0);
            chk("run_start_ignored_cpu_rst",  64'(bus.cpu_reset), 64'd0);
        end

        budget = 0;
        while (!bus.done && budget < TO + 60) begin
            @(negedge clock);
            budget++;
        end
        if (!bus.done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_wait: got done=0 after %0d cycles, expected done=1", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 time units, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.expected = '0;
        bus.prog_len = '0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;

        repeat (2) @(negedge clock);
        check_reset_vals();
        #2 reset = 1'b0;

        // Reference program, contiguous then every-other-cycle valid.
        run_test(1'b0, 32'd144, 4, 0, 37, 32'd0, 1'b1, 1'b0, 0);
        run_test(1'b0, 32'd144, 4, 1, 37, 32'd0, 1'b1, 1'b0, 0);
        // ecall-style pass and fail.
        run_test(1'b1, 32'd0, 3, 0, 10, 32'd1, 1'b0, 1'b0, 0);
        run_test(1'b1, 32'd0, 3, 2, 12, 32'd7, 1'b0, 1'b0, 0);
        // Timeout, and a match on the timeout edge.
        run_test(1'b0, 32'hdead_beef, 2, 0, 0, 32'd0, 1'b0, 1'b0, 0);
        run_test(1'b0, 32'h1234_5678, 2, 0, TO, 32'd0, 1'b0, 1'b0, 0);
        // Reset after two of four words, then a full reload from address 0.
        run_test(1'b0, 32'd144, 4, 0, 5, 32'd0, 1'b1, 1'b0, 2);
        run_test(1'b0, 32'd144, 4, 0, 5, 32'd0, 1'b1, 1'b0, 0);
        // Zero length, over-long length with start pulsed during RUN.
        run_test(1'b0, 32'd77, 0, 0, 3, 32'd0, 1'b0, 1'b0, 0);
        run_test(1'b1, 32'd0, DEPTH + 5, 2, 20, 32'd9, 1'b0, 1'b1, 0);

        for (int k = 0; k < 12; k++) begin
            run_test(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, DEPTH + 4),
                     $urandom_range(0, 2), $urandom_range(0, TO + 5),
                     32'($urandom_range(0, 15)), 1'b0, 1'b0, 0);
        end

        repeat (3) @(negedge clock);
        chk("mem_queue_empty", 64'(q_mem.size()), 64'd0);
        chk("res_queue_empty", 64'(q_res.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_run_controller.md
# pipe_run_controller

Synthesizable run controller for the pipelined RV32I processor. It streams a program image into processor memory through the `memEn`/`memAddr`/`memData` load port and holds the processor in reset for a programmable time. It then releases the core and watches `a0`/`a7`/`gp` for a completion condition, reporting pass/fail, cycle count and timeout. It sits between a host/FPGA loader and the `processor` top, and replaces hard-wired bench checking with a reusable, parametrised block.

## Interface
Parameters:
- `WIDTH`, 32: data and register width.
- `DEPTH_WORDS`, 1024: maximum program length in words.
- `RESET_CYCLES`, 2: cycles `cpu_reset` stays high after the last load write (≥1).
- `TIMEOUT_CYCLES`, 5000: RUN cycles before timeout (≥1).
- `CNT_W`, 32: width of the cycle counter.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle start pulse.
- `mode`  in  1  0 = a0-match, 1 = ecall/tohost style (sampled at start).
- `expected`  in  WIDTH  a0 target for mode 0 (sampled at start).
- `prog_len`  in  $clog2(DEPTH_WORDS)+1  word count (sampled at start).
- `ld_valid`  in  1  load word valid.
- `ld_ready`  out  1  controller accepts a word.
- `ld_data`  in  WIDTH  program word.
- `cpu_reset`  out  1  reset to processor.
- `memEn`, `memAddr`, `memData`  out  1/WIDTH/WIDTH  processor load port, registered.
- `gp`, `a7`, `a0`  in  WIDTH  observed processor registers.
- `busy`  out  1  state is not IDLE/DONE.
- `done`  out  1  sticky completion.
- `pass`  out  1  sticky pass.
- `timeout`  out  1  sticky timeout.
- `fail_code`  out  WIDTH  `gp>>1` on mode-1 failure, else 0.
- `cycle_count`  out  CNT_W  RUN cycles elapsed.

## Operation
- States: IDLE → LOAD → HOLD → RUN → DONE.
- IDLE/DONE: `start` latches `mode`, `expected` and `min(prog_len, DEPTH_WORDS)`, clears `done/pass/timeout/fail_code/cycle_count`, and enters LOAD. If the length is 0, it enters HOLD directly. `start` is ignored in LOAD/HOLD/RUN.
- LOAD: `ld_ready`=1. On each `ld_valid&&ld_ready`, write word index i to `memAddr`=i*4 with `memData`=`ld_data`, then i++. After the last handshake, enter HOLD. Gaps in `ld_valid` are permitted.
- HOLD: `cpu_reset`=1 for exactly RESET_CYCLES cycles, then enter RUN.
- RUN: `cpu_reset`=0 and `cycle_count` increments every cycle, saturating at its maximum.
  - Mode 0: `a0==expected` → pass.
  - Mode 1: `a7==93` → pass if `gp==1`, otherwise fail with `fail_code=gp>>1`.
  - `cycle_count==TIMEOUT_CYCLES` with no match → `timeout`=1, `pass`=0.
  - A match and a timeout in the same cycle: the match wins.
  - Every exit sets `done` and enters DONE.
- DONE: `cpu_reset`=1 (core frozen). Results hold until the next `start`.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, `ld_ready`=0, `memEn`=0, `memAddr`=0, `memData`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `fail_code`=0, `cycle_count`=0.
- `start` at edge t → LOAD visible in cycle t+1, with `ld_ready` high.
- Handshake at edge k → `memEn`=1 with address/data during cycle k+1. Otherwise `memEn`=0.
- `cpu_reset` is high from reset through HOLD, falls at the first RUN cycle, and rises again in DONE.
- Conditions are evaluated on registered-boundary samples of `a0/a7/gp` at each RUN edge. `done` asserts the cycle after the matching edge. `cycle_count` then equals the number of RUN edges, including the matching edge.
- Asserting `reset` at any time (including mid-LOAD or mid-RUN) forces reset values immediately, with no handshake completion.

## Test plan
- Load 4 words (0x13, 0x93, 0x113, 0x193), mode 0, expected=144, a0=144 held from RUN edge 37 → `memEn` pulses at addresses 0,4,8,12 with matching data. `cpu_reset` falls 2 cycles after the last write. `done`=1, `pass`=1, `cycle_count`=37.
- Same load with `ld_valid` toggling every other cycle → identical memory writes, no duplicates or drops, 4 `memEn` pulses total.
- Mode 1, a7=93 with gp=1 → `pass`=1. Restart with a7=93, gp=7 → `pass`=0, `fail_code`=3, `timeout`=0.
- TIMEOUT_CYCLES=50, a0 never matches → `done`=1, `timeout`=1, `pass`=0, `cycle_count`=50, `cpu_reset`=1.
- Assert `reset` after 2 of 4 load words → all outputs at reset values next sample and state IDLE. A subsequent `start` reloads from address 0.
- `prog_len`=0 and `prog_len`=DEPTH_WORDS+5 → the first skips LOAD (no `memEn`, HOLD immediately). The second performs exactly DEPTH_WORDS writes. `start` pulsed during RUN is ignored.
